icache_refill_engine: RTL and testbench
=======================================

// Module: icache_refill_engine
// PURPOSE
//  Parametrised I$ miss/refill engine for the next-gen fetch unit. Accepts one line miss from the tag stage and issues a
//  single AXI4 read burst, critical-word-first (WRAP) or line-aligned (INCR). Forwards the missed instruction early and
//  writes the assembled line plus tag into the victim way chosen round-robin. Aborts cleanly on branch redirect.
// PARAMETERS
//  ADDR_W      32  byte-address width
//  LINE_BYTES  32  cache-line size in bytes (power of 2, >= AXI_DATA_W/8)
//  AXI_DATA_W  32  AXI read data width: 32 or 64
//  NUM_SETS    64  sets (power of 2); SET_W=log2(NUM_SETS), OFF_W=log2(LINE_BYTES), TAG_W=ADDR_W-SET_W-OFF_W
//  NUM_WAYS    4   ways (power of 2, >=2)
//  WRAP_EN     1   1: WRAP burst from the missed beat when BEATS in {2,4,8,16}; else INCR from the line base
// PORTS
//  clk            in   1                 clock
//  rst            in   1                 reset, asynchronous, active-high
//  miss_valid     in   1                 miss request
//  miss_ready     out  1                 engine IDLE and no flush this cycle
//  miss_addr      in   ADDR_W            missed PC (word-aligned)
//  flush          in   1                 branch redirect; discard the in-flight refill
//  axi_ibus_ar*   out  addr/len/size/burst/valid  AXI4 AR channel (arready in)
//  axi_ibus_r*    in   data/resp/valid/last       AXI4 R channel (rready out, constant 1)
//  crit_valid     out  1                 1-cycle pulse: missed instruction available
//  crit_data      out  32                missed instruction
//  crit_pc        out  ADDR_W            its PC (= latched miss_addr)
//  refill_en      out  NUM_WAYS          one-hot way write enable, 1-cycle pulse
//  refill_set     out  SET_W             set index of the refilled line
//  refill_tag     out  TAG_W             tag of the refilled line
//  refill_data    out  LINE_BYTES*8      assembled line, word 0 at LSBs
//  refill_err     out  1                 1-cycle pulse: burst completed with SLVERR/DECERR
//  resume_fetch   out  1                 1-cycle pulse one cycle after refill_en or refill_err
//  busy           out  1                 state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE; arvalid, crit_valid, refill_en, refill_err, resume_fetch, busy = 0; victim ptr = 0; flags clear.
//  - BEATS = LINE_BYTES*8/AXI_DATA_W; arlen = BEATS-1; arsize = log2(AXI_DATA_W/8); rready = 1.
//  - WRAP: araddr = miss_addr aligned to AXI_DATA_W/8, arburst = 2'b10, start_beat = missed beat index.
//    INCR: araddr = line base, arburst = 2'b01, start_beat = 0. Beat k lands in slot (start_beat+k) mod BEATS (wraps).
//  - IDLE: miss_valid & miss_ready latches addr, clears abort/err, -> ADDR; arvalid = 1 in the next cycle.
//  - ADDR: arvalid held until arready (never dropped, even on flush); on handshake arvalid = 0, beat ctr = 0, -> DATA.
//  - DATA: each rvalid stores the beat and increments the ctr; rresp[1] sets err (sticky). When the stored beat holds
//    the missed word and abort = 0, err = 0 (including that beat): crit_valid the next cycle. crit_data = 32-bit lane
//    chosen by miss_addr[2] when AXI_DATA_W = 64. On rlast -> WRITE. Count mismatch vs arlen is a protocol error (assert).
//  - WRITE (1 cycle): abort = 0 & err = 0: refill_en = onehot(victim), victim ptr += 1 (mod NUM_WAYS).
//    err = 1 & abort = 0: refill_err, ptr held. abort = 1: no pulse. resume_fetch next cycle unless abort. -> IDLE.
//  - flush in ADDR/DATA/WRITE sets abort: burst still fully drained, no further crit/refill/resume pulses.
//    flush in IDLE: no effect; miss_valid refused that cycle.
//  - Latency (no stalls, WRAP): miss accept T, arvalid T+1, first beat T+2 earliest, crit_valid one cycle after the
//    first beat, refill_en one cycle after rlast, resume_fetch one cycle later.
//  - Async rst mid-burst: immediate return to reset values; the AXI slave shares rst.
// TESTING
//  1. Defaults, miss 0x1014, arready at once, beats D0..D7 -> araddr 0x1014, arlen 7, arsize 2, arburst 2'b10;
//     crit_data = D0; line words 5,6,7,0..4 = D0..D7; set 0, tag 2, refill_en 4'b0001; next miss gives 4'b0010.
//  2. WRAP_EN=0, miss 0x1014 -> araddr 0x1000, arburst 2'b01; crit_valid after beat 5 (D5); word i = Di.
//  3. flush after beat 3 -> rready held 1 through rlast; no refill_en/crit/resume; busy drops; miss_ready = 1 next.
//  4. rresp 2'b10 on beat 2 -> refill_err pulse, refill_en stays 0, victim ptr unchanged, resume_fetch pulses.
//  5. AXI_DATA_W=64, LINE_BYTES=64, miss 0x2004 -> arlen 7, arsize 3, crit_data = rdata[63:32] of beat 0.
//  6. rst asserted mid-DATA without a clock edge -> arvalid/busy/pulses 0 immediately; clean miss accepted afterwards.

Source files
------------

// File: rtl/icache_refill_engine.sv
// Instruction-cache miss/refill engine: one AXI4 read burst per line miss, early forwarding of the
// missed instruction, and a write of the assembled line into a round-robin victim way.

module icache_refill_engine_chk #(
    parameter int BEATS = 8,
    parameter int CNT_W = 4
) (
    input logic             clk,
    input logic             rst,
    input logic             in_data,
    input logic             rvalid,
    input logic             rlast,
    input logic [CNT_W-1:0] beat_cnt
);
    // A burst must deliver exactly BEATS beats, with rlast on the final one and nowhere else.
    always @(posedge clk) begin
        if (!rst && in_data && rvalid) begin
            assert (rlast == (beat_cnt == CNT_W'(BEATS - 1)));
        end
    end
endmodule

module icache_refill_engine #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 32,
    parameter int AXI_DATA_W = 32,
    parameter int NUM_SETS   = 64,
    parameter int NUM_WAYS   = 4,
    parameter int WRAP_EN    = 1,
    localparam int SET_W  = $clog2(NUM_SETS),
    localparam int OFF_W  = $clog2(LINE_BYTES),
    localparam int TAG_W  = ADDR_W - SET_W - OFF_W,
    localparam int LINE_W = LINE_BYTES * 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_valid,
    output logic                  miss_ready,
    input  logic [ADDR_W-1:0]     miss_addr,
    input  logic                  flush,
    output logic [ADDR_W-1:0]     axi_ibus_araddr,
    output logic [7:0]            axi_ibus_arlen,
    output logic [2:0]            axi_ibus_arsize,
    output logic [1:0]            axi_ibus_arburst,
    output logic                  axi_ibus_arvalid,
    input  logic                  axi_ibus_arready,
    input  logic [AXI_DATA_W-1:0] axi_ibus_rdata,
    input  logic [1:0]            axi_ibus_rresp,
    input  logic                  axi_ibus_rvalid,
    input  logic                  axi_ibus_rlast,
    output logic                  axi_ibus_rready,
    output logic                  crit_valid,
    output logic [31:0]           crit_data,
    output logic [ADDR_W-1:0]     crit_pc,
    output logic [NUM_WAYS-1:0]   refill_en,
    output logic [SET_W-1:0]      refill_set,
    output logic [TAG_W-1:0]      refill_tag,
    output logic [LINE_W-1:0]     refill_data,
    output logic                  refill_err,
    output logic                  resume_fetch,
    output logic                  busy
);
    localparam int BEATS    = LINE_W / AXI_DATA_W;
    localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W    = $clog2(BEATS) + 1;
    localparam int SIZE     = $clog2(AXI_DATA_W / 8);
    localparam int WAY_W    = $clog2(NUM_WAYS);
    localparam bit USE_WRAP = (WRAP_EN != 0) &&
                              (BEATS == 2 || BEATS == 4 || BEATS == 8 || BEATS == 16);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        WRITE = 2'd3
    } state_t;

    function automatic logic [BEAT_W-1:0] beat_of(input logic [ADDR_W-1:0] a);
        logic [OFF_W-1:0] off;
        off = a[OFF_W-1:0] >> SIZE;
        return off[BEAT_W-1:0];
    endfunction

    function automatic logic [NUM_WAYS-1:0] onehot(input logic [WAY_W-1:0] idx);
        logic [NUM_WAYS-1:0] v;
        v      = {NUM_WAYS{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   addr_r, araddr_r;
    logic [BEAT_W-1:0]   start_beat_r;
    logic [CNT_W-1:0]    beat_cnt_r;
    logic [WAY_W-1:0]    victim_r;
    logic                abort_r, err_r, arvalid_r;
    logic [LINE_W-1:0]   line_r;
    logic                crit_valid_r, refill_err_r, resume_r;
    logic [31:0]         crit_data_r;
    logic [NUM_WAYS-1:0] refill_en_r;

    logic                accept_s, abort_s, err_s, crit_hit_s;
    logic [BEAT_W-1:0]   slot_s;
    logic [31:0]         crit_word_s;

    assign miss_ready = (state_r == IDLE) && !flush;
    assign accept_s   = miss_valid && miss_ready;
    assign abort_s    = abort_r || flush;
    assign err_s      = err_r || (axi_ibus_rresp == 2'b10) || (axi_ibus_rresp == 2'b11);
    // Beat k of the burst lands in line slot (start_beat + k), wrapping modulo BEATS.
    assign slot_s     = start_beat_r + beat_cnt_r[BEAT_W-1:0];
    assign crit_hit_s = (state_r == DATA) && axi_ibus_rvalid && (slot_s == beat_of(addr_r)) &&
                        !abort_s && !err_s;

    generate
        if (AXI_DATA_W == 32) begin : g_lane32
            assign crit_word_s = axi_ibus_rdata;
        end else begin : g_lane64
            assign crit_word_s = addr_r[2] ? axi_ibus_rdata[63:32] : axi_ibus_rdata[31:0];
        end
    endgenerate

    assign axi_ibus_araddr  = araddr_r;
    assign axi_ibus_arlen   = 8'(BEATS - 1);
    assign axi_ibus_arsize  = 3'(SIZE);
    assign axi_ibus_arburst = USE_WRAP ? 2'b10 : 2'b01;
    assign axi_ibus_arvalid = arvalid_r;
    assign axi_ibus_rready  = 1'b1;
    assign crit_valid       = crit_valid_r;
    assign crit_data        = crit_data_r;
    assign crit_pc          = addr_r;
    assign refill_en        = refill_en_r;
    assign refill_set       = addr_r[OFF_W +: SET_W];
    assign refill_tag       = addr_r[ADDR_W-1 -: TAG_W];
    assign refill_data      = line_r;
    assign refill_err       = refill_err_r;
    assign resume_fetch     = resume_r;
    assign busy             = (state_r != IDLE);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = ADDR;
                else          state_s = IDLE;
            end
            ADDR: begin
                if (arvalid_r && axi_ibus_arready) state_s = DATA;
                else                               state_s = ADDR;
            end
            DATA: begin
                if (axi_ibus_rvalid && axi_ibus_rlast) state_s = WRITE;
                else                                   state_s = DATA;
            end
            WRITE:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Request latch, beat capture, output pulses and victim bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r       <= {ADDR_W{1'b0}};
            araddr_r     <= {ADDR_W{1'b0}};
            start_beat_r <= {BEAT_W{1'b0}};
            beat_cnt_r   <= {CNT_W{1'b0}};
            victim_r     <= {WAY_W{1'b0}};
            abort_r      <= 1'b0;
            err_r        <= 1'b0;
            arvalid_r    <= 1'b0;
            line_r       <= {LINE_W{1'b0}};
            crit_valid_r <= 1'b0;
            crit_data_r  <= 32'h0000_0000;
            refill_en_r  <= {NUM_WAYS{1'b0}};
            refill_err_r <= 1'b0;
            resume_r     <= 1'b0;
        end else begin
            crit_valid_r <= 1'b0;
            refill_en_r  <= {NUM_WAYS{1'b0}};
            refill_err_r <= 1'b0;
            resume_r     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        addr_r       <= miss_addr;
                        araddr_r     <= USE_WRAP ? {miss_addr[ADDR_W-1:SIZE], {SIZE{1'b0}}}
                                                 : {miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        start_beat_r <= USE_WRAP ? beat_of(miss_addr) : {BEAT_W{1'b0}};
                        abort_r      <= 1'b0;
                        err_r        <= 1'b0;
                        arvalid_r    <= 1'b1;
                    end
                end
                ADDR: begin
                    // The address phase always completes; a redirect only marks the refill as dead.
                    if (flush) abort_r <= 1'b1;
                    if (arvalid_r && axi_ibus_arready) begin
                        arvalid_r  <= 1'b0;
                        beat_cnt_r <= {CNT_W{1'b0}};
                    end
                end
                DATA: begin
                    if (flush) abort_r <= 1'b1;
                    if (axi_ibus_rvalid) begin
                        for (int b = 0; b < BEATS; b++) begin
                            if (slot_s == BEAT_W'(b)) line_r[b*AXI_DATA_W +: AXI_DATA_W] <= axi_ibus_rdata;
                        end
                        beat_cnt_r <= beat_cnt_r + 1'b1;
                        if (err_s) err_r <= 1'b1;
                        if (crit_hit_s) begin
                            crit_valid_r <= 1'b1;
                            crit_data_r  <= crit_word_s;
                        end
                        // Write pulses are raised on the rlast edge so they coincide with the WRITE cycle.
                        if (axi_ibus_rlast && !abort_s) begin
                            if (err_s) begin
                                refill_err_r <= 1'b1;
                            end else begin
                                refill_en_r <= onehot(victim_r);
                                victim_r    <= victim_r + 1'b1;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (flush) abort_r <= 1'b1;
                    if (!abort_s) resume_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    icache_refill_engine_chk #(.BEATS(BEATS), .CNT_W(CNT_W)) u_chk (
        .clk      (clk),
        .rst      (rst),
        .in_data  (state_r == DATA),
        .rvalid   (axi_ibus_rvalid),
        .rlast    (axi_ibus_rlast),
        .beat_cnt (beat_cnt_r)
    );
endmodule

// File: tb/tb_icache_refill_engine.sv
// Directed bench for icache_refill_engine: three instances (WRAP 32-bit, INCR 32-bit, WRAP 64-bit)
// share one stimulus stream and are checked against hand-computed values.
module tb_icache_refill_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_valid = 1'b0, flush = 1'b0, arready = 1'b0, rvalid = 1'b0, rlast = 1'b0;
    logic [31:0] miss_addr = 32'h0;
    logic [63:0] rdata = 64'h0;
    logic [1:0]  rresp = 2'b00;

    logic        miss_ready[3], arvalid[3], rready[3], crit_valid[3], refill_err[3], resume[3], busy[3];
    logic [31:0] araddr[3], crit_data[3], crit_pc[3];
    logic [7:0]  arlen[3];
    logic [2:0]  arsize[3];
    logic [1:0]  arburst[3];
    logic [3:0]  refill_en[3];
    logic [5:0]  refill_set[3];
    logic [20:0] tag0, tag1;
    logic [19:0] tag2;
    logic [255:0] data0, data1;
    logic [511:0] data2;

    int n_tests = 0, n_fail = 0;
    int crit_cnt[3], ren_cnt[3], res_cnt[3];
    logic [31:0] crit_cap[3];

    always #5 clk = ~clk;

    icache_refill_engine #(.WRAP_EN(1)) dut0 (
        .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_ready(miss_ready[0]), .miss_addr(miss_addr),
        .flush(flush), .axi_ibus_araddr(araddr[0]), .axi_ibus_arlen(arlen[0]), .axi_ibus_arsize(arsize[0]),
        .axi_ibus_arburst(arburst[0]), .axi_ibus_arvalid(arvalid[0]), .axi_ibus_arready(arready),
        .axi_ibus_rdata(rdata[31:0]), .axi_ibus_rresp(rresp), .axi_ibus_rvalid(rvalid), .axi_ibus_rlast(rlast),
        .axi_ibus_rready(rready[0]), .crit_valid(crit_valid[0]), .crit_data(crit_data[0]), .crit_pc(crit_pc[0]),
        .refill_en(refill_en[0]), .refill_set(refill_set[0]), .refill_tag(tag0), .refill_data(data0),
        .refill_err(refill_err[0]), .resume_fetch(resume[0]), .busy(busy[0]));

    icache_refill_engine #(.WRAP_EN(0)) dut1 (
        .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_ready(miss_ready[1]), .miss_addr(miss_addr),
        .flush(flush), .axi_ibus_araddr(araddr[1]), .axi_ibus_arlen(arlen[1]), .axi_ibus_arsize(arsize[1]),
        .axi_ibus_arburst(arburst[1]), .axi_ibus_arvalid(arvalid[1]), .axi_ibus_arready(arready),
        .axi_ibus_rdata(rdata[31:0]), .axi_ibus_rresp(rresp), .axi_ibus_rvalid(rvalid), .axi_ibus_rlast(rlast),
        .axi_ibus_rready(rready[1]), .crit_valid(crit_valid[1]), .crit_data(crit_data[1]), .crit_pc(crit_pc[1]),
        .refill_en(refill_en[1]), .refill_set(refill_set[1]), .refill_tag(tag1), .refill_data(data1),
        .refill_err(refill_err[1]), .resume_fetch(resume[1]), .busy(busy[1]));

    icache_refill_engine #(.AXI_DATA_W(64), .LINE_BYTES(64)) dut2 (
        .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_ready(miss_ready[2]), .miss_addr(miss_addr),
        .flush(flush), .axi_ibus_araddr(araddr[2]), .axi_ibus_arlen(arlen[2]), .axi_ibus_arsize(arsize[2]),
        .axi_ibus_arburst(arburst[2]), .axi_ibus_arvalid(arvalid[2]), .axi_ibus_arready(arready),
        .axi_ibus_rdata(rdata), .axi_ibus_rresp(rresp), .axi_ibus_rvalid(rvalid), .axi_ibus_rlast(rlast),
        .axi_ibus_rready(rready[2]), .crit_valid(crit_valid[2]), .crit_data(crit_data[2]), .crit_pc(crit_pc[2]),
        .refill_en(refill_en[2]), .refill_set(refill_set[2]), .refill_tag(tag2), .refill_data(data2),
        .refill_err(refill_err[2]), .resume_fetch(resume[2]), .busy(busy[2]));

    // Pulse counters sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (crit_valid[i]) begin
                crit_cnt[i] <= crit_cnt[i] + 1;
                crit_cap[i] <= crit_data[i];
            end
            if (refill_en[i] != 4'b0000) ren_cnt[i] <= ren_cnt[i] + 1;
            if (resume[i]) res_cnt[i] <= res_cnt[i] + 1;
        end
    end

    function automatic logic [31:0] lo(input int tn, input int k);
        return {16'hC0DE, 8'(tn), 8'(k)};
    endfunction

    function automatic logic [31:0] hi(input int tn, input int k);
        return {16'hF00D, 8'(tn), 8'(k)};
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_miss(input logic [31:0] addr);
        miss_addr  = addr;
        miss_valid = 1'b1;
        step();
        miss_valid = 1'b0;
        arready    = 1'b1;
        step();
        arready    = 1'b0;
    endtask

    // Eight back-to-back beats; optional error beat and a one-cycle flush alongside a given beat.
    task automatic send_beats(input int tn, input int err_beat, input int flush_beat);
        for (int k = 0; k < 8; k++) begin
            rvalid = 1'b1;
            rdata  = {hi(tn, k), lo(tn, k)};
            rresp  = (k == err_beat) ? 2'b10 : 2'b00;
            rlast  = (k == 7);
            flush  = (k == flush_beat);
            chk("rready_high", rready[0], 1'b1);
            step();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        flush  = 1'b0;
    endtask

    initial begin
        logic [31:0] d[8];
        int c0, c1, r0, s0;

        // Reset state
        #12;
        chk("rst_arvalid", arvalid[0], 1'b0);
        chk("rst_busy", busy[0], 1'b0);
        chk("rst_crit", crit_valid[0], 1'b0);
        chk("rst_refill_en", refill_en[0], 4'b0000);
        chk("rst_refill_err", refill_err[0], 1'b0);
        chk("rst_resume", resume[0], 1'b0);
        chk("rst_miss_ready", miss_ready[0], 1'b1);
        rst = 1'b0;
        step();

        // Test 1 / 2: miss 0x1014, WRAP on dut0, INCR on dut1, arready one cycle late
        for (int k = 0; k < 8; k++) d[k] = lo(1, k);
        miss_addr  = 32'h0000_1014;
        miss_valid = 1'b1;
        step();
        miss_valid = 1'b0;
        chk("t1_arvalid", arvalid[0], 1'b1);
        chk("t1_araddr", araddr[0], 32'h0000_1014);
        chk("t1_arlen", arlen[0], 8'd7);
        chk("t1_arsize", arsize[0], 3'd2);
        chk("t1_arburst", arburst[0], 2'b10);
        chk("t1_busy", busy[0], 1'b1);
        chk("t1_miss_ready", miss_ready[0], 1'b0);
        chk("t2_araddr", araddr[1], 32'h0000_1000);
        chk("t2_arburst", arburst[1], 2'b01);
        step();
        chk("t1_arvalid_hold", arvalid[0], 1'b1);
        arready = 1'b1;
        step();
        arready = 1'b0;
        chk("t1_arvalid_drop", arvalid[0], 1'b0);
        for (int k = 0; k < 8; k++) begin
            rvalid = 1'b1;
            rdata  = {hi(1, k), lo(1, k)};
            rlast  = (k == 7);
            step();
            chk("t1_crit_wrap", crit_valid[0], (k == 0));
            chk("t2_crit_incr", crit_valid[1], (k == 5));
            if (k == 0) begin
                chk("t1_crit_data", crit_data[0], d[0]);
                chk("t1_crit_pc", crit_pc[0], 32'h0000_1014);
                chk("t1_crit_data64", crit_data[2], hi(1, 0));
            end
            if (k == 5) chk("t2_crit_data", crit_data[1], d[5]);
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        chk("t1_refill_en", refill_en[0], 4'b0001);
        chk("t1_refill_set", refill_set[0], 6'd0);
        chk("t1_refill_tag", tag0, 21'd2);
        chk("t1_refill_data", data0, {d[2], d[1], d[0], d[7], d[6], d[5], d[4], d[3]});
        chk("t1_resume_early", resume[0], 1'b0);
        chk("t2_refill_en", refill_en[1], 4'b0001);
        chk("t2_refill_data", data1, {d[7], d[6], d[5], d[4], d[3], d[2], d[1], d[0]});
        step();
        chk("t1_resume", resume[0], 1'b1);
        chk("t1_refill_en_off", refill_en[0], 4'b0000);
        chk("t1_busy_off", busy[0], 1'b0);
        step();
        chk("t1_resume_off", resume[0], 1'b0);

        // Test 5: 64-bit bus, 64-byte line, miss 0x2004; second miss on dut0 takes way 1
        miss_addr  = 32'h0000_2004;
        miss_valid = 1'b1;
        step();
        miss_valid = 1'b0;
        chk("t5_araddr", araddr[2], 32'h0000_2000);
        chk("t5_arlen", arlen[2], 8'd7);
        chk("t5_arsize", arsize[2], 3'd3);
        chk("t5_arburst", arburst[2], 2'b10);
        arready = 1'b1;
        step();
        arready = 1'b0;
        c0 = crit_cnt[2];
        send_beats(5, -1, -1);
        chk("t5_crit_cnt", crit_cnt[2] - c0, 1);
        chk("t5_crit_data", crit_cap[2], hi(5, 0));
        chk("t5_refill_en64", refill_en[2], 4'b0010);
        chk("t5_refill_tag64", tag2, 20'd2);
        chk("t5_refill_set64", refill_set[2], 6'd0);
        chk("t1_next_way", refill_en[0], 4'b0010);
        step();
        chk("t5_resume", resume[0], 1'b1);

        // Test 4: SLVERR on beat 2 of miss 0x3008
        c1 = crit_cnt[1];
        start_miss(32'h0000_3008);
        send_beats(4, 2, -1);
        chk("t4_refill_err", refill_err[0], 1'b1);
        chk("t4_refill_en", refill_en[0], 4'b0000);
        chk("t4_crit_on_err_beat", crit_cnt[1] - c1, 0);
        step();
        chk("t4_resume", resume[0], 1'b1);
        chk("t4_refill_err_off", refill_err[0], 1'b0);

        // Flush while idle refuses the miss that cycle
        miss_addr  = 32'h0000_401C;
        miss_valid = 1'b1;
        flush      = 1'b1;
        #1;
        chk("idle_flush_ready", miss_ready[0], 1'b0);
        step();
        chk("idle_flush_busy", busy[0], 1'b0);
        flush = 1'b0;
        #1;
        chk("idle_ready_back", miss_ready[0], 1'b1);

        // Test 3: accept 0x401C, flush alongside beat 4; burst drained, no refill/resume
        step();
        miss_valid = 1'b0;
        arready    = 1'b1;
        step();
        arready = 1'b0;
        c0 = crit_cnt[0];
        c1 = crit_cnt[1];
        r0 = ren_cnt[0];
        s0 = res_cnt[0];
        send_beats(3, -1, 4);
        chk("t3_refill_en", refill_en[0], 4'b0000);
        chk("t3_busy_write", busy[0], 1'b1);
        step();
        chk("t3_busy_off", busy[0], 1'b0);
        chk("t3_miss_ready", miss_ready[0], 1'b1);
        step();
        chk("t3_crit_wrap_cnt", crit_cnt[0] - c0, 1);
        chk("t3_crit_incr_cnt", crit_cnt[1] - c1, 0);
        chk("t3_refill_cnt", ren_cnt[0] - r0, 0);
        chk("t3_resume_cnt", res_cnt[0] - s0, 0);

        // Victim pointer held across the error and the flushed refill
        start_miss(32'h0000_5000);
        send_beats(6, -1, -1);
        chk("ptr_after_err_flush", refill_en[0], 4'b0100);
        step();
        chk("ptr_resume", resume[0], 1'b1);

        // Test 6: asynchronous reset mid-DATA while crit_valid is high
        start_miss(32'h0000_6014);
        rvalid = 1'b1;
        rdata  = {hi(7, 0), lo(7, 0)};
        step();
        chk("t6_crit_before", crit_valid[0], 1'b1);
        rvalid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_crit_rst", crit_valid[0], 1'b0);
        chk("t6_busy_rst", busy[0], 1'b0);
        chk("t6_arvalid_rst", arvalid[0], 1'b0);
        chk("t6_busy64_rst", busy[2], 1'b0);
        chk("t6_ready_rst", miss_ready[0], 1'b1);
        step();
        rst = 1'b0;
        step();
        for (int k = 0; k < 8; k++) d[k] = lo(8, k);
        start_miss(32'h0000_1014);
        send_beats(8, -1, -1);
        chk("t6_refill_en", refill_en[0], 4'b0001);
        chk("t6_crit_data", crit_cap[0], d[0]);
        chk("t6_refill_data", data0, {d[2], d[1], d[0], d[7], d[6], d[5], d[4], d[3]});
        step();
        chk("t6_resume", resume[0], 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
